lcd_bus_responder: RTL and testbench

Synthesizable model of the character-LCD controller side of the 8-bit E/RS/RW/DB parallel bus. It accepts instruction and data writes from an LCD-driving initiator, answers busy-flag/address and DDRAM reads, and holds a 128-byte DDRAM image readable through a side port. It stands in for the physical panel in on-chip loopback and self-test builds, so the LCD command sequencers can be exercised without hardware.

---
 rtl/lcd_bus_responder.sv | 162 ++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// Controller side of an 8-bit E/RS/RW/DB character-LCD bus: accepts instruction and
// data writes, answers status and DDRAM reads, and keeps a 128-byte DDRAM image.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       E,
  input  logic       RS,
  input  logic       RW,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic [2:0] disp_ctrl,
  output logic       viol,
  output logic       unsup,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES);

  typedef enum logic [1:0] {ST_CLEAR, ST_BUSY, ST_IDLE} state_t;

  state_t      state_reg;
  logic        e_q_reg, rs_q_reg, rw_q_reg, e_prev_reg;
  logic [7:0]  db_q_reg;
  logic        cap_rs_reg, cap_rw_reg;
  logic [7:0]  cap_db_reg;
  logic [6:0]  idx_reg, ac_reg;
  logic [15:0] cnt_reg;
  logic        id_reg;
  logic [2:0]  disp_reg;
  logic        viol_reg, unsup_reg, db_oe_reg;
  logic [7:0]  db_out_reg, rd_data_reg;
  logic [7:0]  ddram [0:127];

  logic        strobe, status_rd, data_wr, mem_we;
  logic [6:0]  mem_waddr, ac_step;
  logic [7:0]  mem_wdata;

  // Falling edge of the registered enable; the capture registers still hold the E-high values.
  assign strobe    = e_prev_reg & ~e_q_reg;
  assign status_rd = ~cap_rs_reg & cap_rw_reg;
  assign data_wr   = strobe & (state_reg == ST_IDLE) & cap_rs_reg & ~cap_rw_reg;
  assign ac_step   = id_reg ? ac_reg + 7'd1 : ac_reg - 7'd1;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ac_reg;
    mem_wdata = cap_db_reg;
    if (!RST) begin
      if (state_reg == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = idx_reg;
        mem_wdata = 8'h20;
      end else if (data_wr) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) ddram[mem_waddr] <= mem_wdata;
    rd_data_reg <= ddram[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      e_q_reg    <= 1'b0;
      rs_q_reg   <= 1'b0;
      rw_q_reg   <= 1'b0;
      db_q_reg   <= 8'h00;
      e_prev_reg <= 1'b0;
      cap_rs_reg <= 1'b0;
      cap_rw_reg <= 1'b0;
      cap_db_reg <= 8'h00;
      db_oe_reg  <= 1'b0;
      db_out_reg <= 8'h00;
      state_reg  <= ST_CLEAR;
      idx_reg    <= 7'd0;
      cnt_reg    <= CLEAR_LOAD;
      ac_reg     <= 7'd0;
      id_reg     <= 1'b1;
      disp_reg   <= 3'd0;
      viol_reg   <= 1'b0;
      unsup_reg  <= 1'b0;
    end else begin
      e_q_reg    <= E;
      rs_q_reg   <= RS;
      rw_q_reg   <= RW;
      db_q_reg   <= DB_in;
      e_prev_reg <= e_q_reg;
      if (e_q_reg) begin
        cap_rs_reg <= rs_q_reg;
        cap_rw_reg <= rw_q_reg;
        cap_db_reg <= db_q_reg;
      end
      db_oe_reg  <= e_q_reg & rw_q_reg;
      db_out_reg <= rs_q_reg ? ddram[ac_reg] : {busy, ac_reg};

      if (strobe && !status_rd && state_reg != ST_IDLE) viol_reg <= 1'b1;

      case (state_reg)
        ST_CLEAR: begin
          cnt_reg <= cnt_reg - 16'd1;
          idx_reg <= idx_reg + 7'd1;
          if (idx_reg == 7'd127) state_reg <= (cnt_reg <= 16'd1) ? ST_IDLE : ST_BUSY;
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg - 16'd1;
          if (cnt_reg <= 16'd1) state_reg <= ST_IDLE;
        end
        default: begin
          if (strobe && !status_rd) begin
            state_reg <= ST_BUSY;
            cnt_reg   <= BUSY_LOAD;
            if (cap_rs_reg) begin
              ac_reg <= ac_step;
            end else begin
              // Instruction class is selected by the highest set bit.
              casez (cap_db_reg)
                8'b1???????: ac_reg <= cap_db_reg[6:0];
                8'b01??????: unsup_reg <= 1'b1;
                8'b001?????: ;
                8'b0001????: if (!cap_db_reg[3]) ac_reg <= cap_db_reg[2] ? ac_reg + 7'd1 : ac_reg - 7'd1;
                8'b00001???: disp_reg <= cap_db_reg[2:0];
                8'b000001??: id_reg <= cap_db_reg[1];
                8'b0000001?: begin
                  ac_reg  <= 7'd0;
                  cnt_reg <= CLEAR_LOAD;
                end
                8'b00000001: begin
                  ac_reg    <= 7'd0;
                  id_reg    <= 1'b1;
                  idx_reg   <= 7'd0;
                  cnt_reg   <= CLEAR_LOAD;
                  state_reg <= ST_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign ac        = ac_reg;
  assign disp_ctrl = disp_reg;
  assign viol      = viol_reg;
  assign unsup     = unsup_reg;
  assign DB_oe     = db_oe_reg;
  assign DB_out    = db_out_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomized bench for lcd_bus_responder against a transaction-level model of the panel.
module tb_lcd_bus_responder;

  localparam int BUSY = 40;
  localparam int CLR  = 1600;

  logic       CLK, RST, E, RS, RW;
  logic [7:0] DB_in, DB_out, rd_data;
  logic       DB_oe, busy, viol, unsup;
  logic [6:0] ac, rd_addr;
  logic [2:0] disp_ctrl;

  lcd_bus_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
    .CLK(CLK), .RST(RST), .E(E), .RS(RS), .RW(RW), .DB_in(DB_in),
    .DB_out(DB_out), .DB_oe(DB_oe), .busy(busy), .ac(ac), .disp_ctrl(disp_ctrl),
    .viol(viol), .unsup(unsup), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: panel state after each accepted strobe, plus the cycle busy ends.
  logic [7:0] mem_m [128];
  int         ac_m, disp_m;
  bit         id_m, viol_m, unsup_m;
  int         busy_end;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask

  function automatic bit busy_at(input int c);
    return c < busy_end;
  endfunction

  function automatic int step(input int a, input bit up);
    return up ? (a + 1) % 128 : (a + 127) % 128;
  endfunction

  task automatic sweep(input string tag);
    for (int a = 0; a < 128; a++) begin
      rd_addr = 7'(a);
      tick(1);
      check(tag, rd_data, mem_m[a]);
    end
  endtask

  task automatic wait_idle();
    if (cyc < busy_end) tick(busy_end - cyc);
  endtask

  task automatic do_reset();
    int n;
    RST = 1'b1;
    E   = 1'b0;
    tick(3);
    RST = 1'b0;
    ac_m = 0; id_m = 1'b1; disp_m = 0; viol_m = 1'b0; unsup_m = 1'b0;
    for (int a = 0; a < 128; a++) mem_m[a] = 8'h20;
    busy_end = cyc + CLR;
    check("rst_busy", busy, 1);
    check("rst_ac", ac, 0);
    check("rst_oe", DB_oe, 0);
    check("rst_dbout", DB_out, 0);
    check("rst_viol", viol, 0);
    check("rst_disp", disp_ctrl, 0);
    n = 0;
    while (busy && n < CLR + 100) begin
      tick(1);
      n++;
    end
    check("rst_busy_len", n, CLR);
    $display("[%0d] reset released, busy lasted %0d cycles", cyc, n);
    sweep("rst_ddram");
  endtask

  // One E pulse of 'hi' cycles; at the fall RW goes to 1 and DB to 0xFF on the same edge.
  task automatic access(input bit rs, input bit rw, input logic [7:0] db, input int hi);
    int p;
    bit ok;
    logic [7:0] expv;
    E = 1'b1; RS = rs; RW = rw; DB_in = db;
    tick(hi);
    if (rw) begin
      check("oe_during_read", DB_oe, 1);
      expv = rs ? mem_m[ac_m] : 8'((busy_at(cyc - 1) ? 128 : 0) + ac_m);
      check(rs ? "data_read_bus" : "status_read_bus", DB_out, expv);
    end else begin
      check("oe_during_write", DB_oe, 0);
    end
    E = 1'b0; RW = 1'b1; DB_in = 8'hFF;
    p  = cyc;
    ok = !busy_at(p + 1);
    if (!(!rs && rw)) begin
      if (!ok) begin
        viol_m = 1'b1;
      end else begin
        busy_end = p + 2 + BUSY;
        if (rs) begin
          if (!rw) mem_m[ac_m] = db;
          ac_m = step(ac_m, id_m);
        end else if (db >= 8'h80) ac_m = int'(db) - 128;
        else if (db >= 8'h40) unsup_m = 1'b1;
        else if (db >= 8'h20) ;
        else if (db >= 8'h10) begin
          if (db[3] == 1'b0) ac_m = step(ac_m, db[2]);
        end
        else if (db >= 8'h08) disp_m = int'(db) - 8;
        else if (db >= 8'h04) id_m = db[1];
        else if (db >= 8'h02) begin
          ac_m = 0;
          busy_end = p + 2 + CLR;
        end else if (db == 8'h01) begin
          ac_m = 0;
          id_m = 1'b1;
          for (int a = 0; a < 128; a++) mem_m[a] = 8'h20;
          busy_end = p + 2 + CLR;
        end
      end
    end
    tick(2);
    check("oe_after_fall", DB_oe, 0);
    $display("[%0d] access rs=%0d rw=%0d db=0x%02h %s", cyc, rs, rw, db, ok ? "idle" : "busy");
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_ac"}, ac, ac_m);
    check({tag, "_disp"}, disp_ctrl, disp_m);
    check({tag, "_viol"}, viol, viol_m);
    check({tag, "_unsup"}, unsup, unsup_m);
  endtask

  initial begin
    int kind;
    RST = 1'b1; E = 1'b0; RS = 1'b0; RW = 1'b0; DB_in = 8'h00; rd_addr = 7'd0;
    do_reset();

    // Address then data write, followed by status reads during and after busy.
    access(1'b0, 1'b0, 8'h85, 4);
    tick(45);
    access(1'b1, 1'b0, 8'h48, 4);
    access(1'b0, 1'b1, 8'h00, 4);
    tick(40);
    access(1'b0, 1'b1, 8'h00, 4);
    check("ac_after_data", ac, 7'h06);
    check("viol_after_data", viol, 0);

    // Decrement mode wraps the address counter below zero.
    access(1'b0, 1'b0, 8'h04, 4); tick(45);
    access(1'b0, 1'b0, 8'h80, 4); tick(45);
    access(1'b1, 1'b0, 8'h41, 4); tick(45);
    check("ac_wrap", ac, 7'h7F);

    // A write arriving while busy is flagged and leaves the busy schedule alone.
    access(1'b0, 1'b0, 8'h82, 4); tick(45);
    access(1'b1, 1'b0, 8'h33, 4); tick(1);
    access(1'b1, 1'b0, 8'h55, 4);
    check("viol_busy_write", viol, 1);
    tick(busy_end - 1 - cyc);
    check("busy_before_end", busy, 1);
    tick(1);
    check("busy_at_end", busy, 0);
    check_regs("directed");
    access(1'b0, 1'b0, 8'h06, 3); tick(45);

    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 24);
      if (kind == 0) begin
        access(1'b0, 1'b0, 8'h01, $urandom_range(3, 5));
        tick(200);
      end else if (kind < 8) access(1'b1, 1'b0, 8'($urandom_range(0, 255)), $urandom_range(3, 5));
      else if (kind < 11) access(1'b1, 1'b1, 8'h00, $urandom_range(3, 5));
      else if (kind < 14) access(1'b0, 1'b1, 8'h00, $urandom_range(3, 5));
      else access(1'b0, 1'b0, 8'($urandom_range(2, 255)), $urandom_range(3, 5));
      tick($urandom_range(1, 60));
    end
    wait_idle();
    tick(2);
    check_regs("random");
    sweep("random_ddram");

    // Reset in the middle of a clear restarts the clear from the first entry.
    access(1'b0, 1'b0, 8'h01, 4);
    tick(20);
    do_reset();
    check_regs("after_midclear_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
